// File: rtl/alu_mux_pipe.sv
// Two-stage ALU pipeline with a valid/ready handshake and a running accumulator.
// Stage 1 captures the operands, and stage 2 computes and registers the result and flags.
module alu_mux_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_ADD    = 3'd3,
    OP_SUB    = 3'd4,
    OP_PASS_A = 3'd5,
    OP_PASS_B = 3'd6,
    OP_ACC    = 3'd7
  } op_t;

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             adv2;
  logic             accept;
  logic             move;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;
  assign move     = s1_valid && adv2;

  // A clear in the same cycle as an ACC move takes effect before the add.
  assign acc_base = acc_clr ? ACC_INIT : acc;

  always_comb begin
    sum        = '0;
    nxt_result = '0;
    nxt_carry  = 1'b0;
    case (s1_op)
      OP_AND:    nxt_result = s1_a & s1_b;
      OP_OR:     nxt_result = s1_a | s1_b;
      OP_XOR:    nxt_result = s1_a ^ s1_b;
      OP_ADD: begin
        sum        = {1'b0, s1_a} + {1'b0, s1_b};
        nxt_result = sum[WIDTH-1:0];
        nxt_carry  = sum[WIDTH];
      end
      // The top bit of the widened difference is set exactly when a < b.
      OP_SUB: begin
        sum        = {1'b0, s1_a} - {1'b0, s1_b};
        nxt_result = sum[WIDTH-1:0];
        nxt_carry  = sum[WIDTH];
      end
      OP_PASS_A: nxt_result = s1_a;
      OP_PASS_B: nxt_result = s1_b;
      OP_ACC: begin
        sum        = {1'b0, acc_base} + {1'b0, s1_a};
        nxt_result = sum[WIDTH-1:0];
        nxt_carry  = sum[WIDTH];
      end
      default: nxt_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_AND;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op_t'(op);
      s1_a     <= a;
      s1_b     <= b;
    end else if (move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (adv2) out_valid <= s1_valid;
      if (move) begin
        result <= nxt_result;
        carry  <= nxt_carry;
        zero   <= (nxt_result == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= ACC_INIT;
    end else if (move && s1_op == OP_ACC) begin
      acc <= sum[WIDTH-1:0];
    end else if (acc_clr) begin
      acc <= ACC_INIT;
    end
  end

endmodule

// File: tb/tb_alu_mux_pipe.sv
// Scoreboard bench for alu_mux_pipe: directed beats push expected results, and a monitor pops them.
module tb_alu_mux_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic [7:0] acc;

  typedef struct {
    logic [7:0] res;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       hold_vld = 1'b0;
  logic [7:0] hold_res;
  logic       hold_c;
  logic       hold_z;

  alu_mux_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .zero(zero), .acc(acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one beat and push its expected response when it is accepted.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic ec, output int waits);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back('{er, ec});
      #1;
      in_valid = 1'b0;
      a = 8'hxx;
      b = 8'hxx;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && out_valid) begin
        checks++;
        if (result !== hold_res || carry !== hold_c || zero !== hold_z) begin
          errors++;
          $display("FAIL stall_hold: got %0h/%0b/%0b expected %0h/%0b/%0b",
                   result, carry, zero, hold_res, hold_c, hold_z);
        end
      end
      hold_vld = out_valid && !out_ready;
      hold_res = result;
      hold_c   = carry;
      hold_z   = zero;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got result %0h, expected no beat", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (result !== e.res || carry !== e.c || zero !== (e.res == 8'h00)) begin
            errors++;
            $display("FAIL beat: got %0h/%0b/%0b expected %0h/%0b/%0b",
                     result, carry, zero, e.res, e.c, (e.res == 8'h00));
          end
        end
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 3'd0;
    a = 8'h00;
    b = 8'h00;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_result", {24'b0, result}, 0);
    chk("rst_carry", {31'b0, carry}, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    chk("rst_acc", {24'b0, acc}, 0);
    rst_n = 1'b1;
    idle(1);

    // ADD with wraparound, checking the two-edge latency.
    send(3'd3, 8'hF0, 8'h20, 8'h10, 1'b1, w);
    chk("t1_lat_early", {31'b0, out_valid}, 0);
    idle(1);
    chk("t1_lat_valid", {31'b0, out_valid}, 1);
    idle(2);

    send(3'd4, 8'h05, 8'h05, 8'h00, 1'b0, w);
    send(3'd4, 8'h03, 8'h05, 8'hFE, 1'b1, w);
    idle(3);

    send(3'd0, 8'hCC, 8'hAA, 8'h88, 1'b0, w); chk("t3_rdy_and", w, 0);
    send(3'd1, 8'hCC, 8'hAA, 8'hEE, 1'b0, w); chk("t3_rdy_or", w, 0);
    send(3'd2, 8'hCC, 8'hAA, 8'h66, 1'b0, w); chk("t3_rdy_xor", w, 0);
    send(3'd5, 8'hCC, 8'hAA, 8'hCC, 1'b0, w); chk("t3_rdy_pa", w, 0);
    send(3'd6, 8'hCC, 8'hAA, 8'hAA, 1'b0, w); chk("t3_rdy_pb", w, 0);
    idle(3);

    // Back-pressure while three beats are offered.
    out_ready = 1'b0;
    fork
      begin
        int w2;
        send(3'd3, 8'h01, 8'h02, 8'h03, 1'b0, w2);
        send(3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, w2);
        chk("t4_in_ready_low", {31'b0, in_ready}, 0);
        send(3'd6, 8'h00, 8'h11, 8'h11, 1'b0, w2);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    send(3'd7, 8'h80, 8'h00, 8'h80, 1'b0, w);
    send(3'd7, 8'h90, 8'h00, 8'h10, 1'b1, w);
    idle(3);
    chk("t5_acc_10", {24'b0, acc}, 32'h10);
    // The clear lands on the edge where this ACC beat moves to stage 2.
    send(3'd7, 8'h07, 8'h00, 8'h07, 1'b0, w);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    chk("t5_acc_clr_move", {24'b0, acc}, 32'h07);
    idle(2);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    chk("t5_acc_clr_alone", {24'b0, acc}, 32'h00);
    send(3'd7, 8'h07, 8'h00, 8'h07, 1'b0, w);
    idle(3);
    chk("t5_acc_07", {24'b0, acc}, 32'h07);

    // Reset with both stages full and the output stalled.
    out_ready = 1'b0;
    send(3'd3, 8'h01, 8'h01, 8'h02, 1'b0, w);
    send(3'd1, 8'h10, 8'h01, 8'h11, 1'b0, w);
    chk("t6_full", {31'b0, in_ready}, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_out_valid", {31'b0, out_valid}, 0);
    chk("t6_in_ready", {31'b0, in_ready}, 1);
    chk("t6_acc", {24'b0, acc}, 0);
    out_ready = 1'b1;
    idle(10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
